// File: rtl/audio_pkg.sv
// Shared audio-path constants for the PDM capture and playback blocks.
package audio_pkg;

  localparam int AUDIO_WORD_W = 16;
  localparam int PDM_CLK_DIV  = 50;

  typedef logic [AUDIO_WORD_W-1:0] audio_word_t;

endpackage

// File: rtl/pdm_deserializer_if.sv
// Valid/ready word channel from the PDM capture path to the memory write logic.
interface pdm_deserializer_if
  import audio_pkg::*;
#(
  parameter int WORD_W = AUDIO_WORD_W
);

  logic [WORD_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/pdm_clk_gen.sv
// Enable-gated PDM clock divider with one-cycle rise/fall strobes; shared by
// the capture and playback paths so both run at the same mic rate.
module pdm_clk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = PDM_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic i_enable,
  output logic o_m_clk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam logic [7:0] TERM_CNT = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_m_clk;
  logic       w_term;

  assign w_term = i_enable && (r_div_cnt == TERM_CNT);

  // NOTE: non-blocking assignments let every flop here sample pre-edge values,
  // so the counter and the clock toggle stay in lockstep regardless of order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_m_clk   <= 1'b0;
    end else if (!i_enable) begin
      r_div_cnt <= '0;
      r_m_clk   <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_m_clk   <= ~r_m_clk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

  // Strobes mark the cycle whose closing edge flips the mic clock.
  assign o_rise_stb = w_term && !r_m_clk;
  assign o_fall_stb = w_term &&  r_m_clk;
  assign o_m_clk    = r_m_clk;

endmodule

// File: rtl/pdm_deserializer.sv
// PDM microphone capture: synchronizes mic data, packs WORD_W samples MSB-first
// and offers each word on a valid/ready channel with a sticky overrun flag.
module pdm_deserializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV = PDM_CLK_DIV,
  parameter int WORD_W  = AUDIO_WORD_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               pdm_mic_i,
  output logic               m_clk_o,
  output logic               m_lrsel_o,
  output logic               overrun_o,
  pdm_deserializer_if.master wr
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_enable_d;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [WORD_W-2:0] r_shift;
  logic [WORD_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_fall_stb;
  logic              w_unused_rise_stb;
  logic              w_word_done;
  logic [WORD_W-1:0] w_word;

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clock      (clock),
    .reset      (reset),
    .i_enable   (enable),
    .o_m_clk    (m_clk_o),
    .o_rise_stb (w_unused_rise_stb),
    .o_fall_stb (w_fall_stb)
  );

  // Mic data is asynchronous to clock; only the second flop is ever sampled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pdm_mic_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_word      = {r_shift, r_sync2};
  assign w_word_done = w_fall_stb && (r_bit_cnt == LAST_BIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!enable) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_fall_stb) begin
      r_shift   <= w_word[WORD_W-2:0];
      r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
    end
  end

  // A finished word loads only if the slot is empty or being drained this
  // cycle; otherwise it is dropped and the overrun flag latches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
      r_enable_d <= 1'b0;
    end else begin
      r_enable_d <= enable;
      if (enable && !r_enable_d) begin
        r_overrun <= 1'b0;
      end
      if (w_word_done) begin
        if (!r_valid || wr.ready) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && wr.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign wr.data   = r_data;
  assign wr.valid  = r_valid;
  assign overrun_o = r_overrun;
  assign m_lrsel_o = 1'b0;

endmodule
